time_counter: RTL and testbench

//  BCD time-of-day counter (HH:MM:SS, 24 h) for the digital clock; runs off a 1 s prescaler.

---
 rtl/time_counter_pkg.sv | 48 ++++
 rtl/time_counter_bcd_digit.sv | 37 +++
 rtl/time_counter.sv | 128 ++++++++++++
 tb/tb_time_counter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_counter_pkg.sv
// Shared time-of-day definitions: BCD digit limits, the HHMM word layout
// and the load-validity rule. The keyboard and alarm logic import the same
// package so that every block agrees on what a legal time looks like.
package time_counter_pkg;

    localparam logic [3:0] SEC10_MAX     = 4'd5;
    localparam logic [3:0] MIN10_MAX     = 4'd5;
    localparam logic [3:0] HR10_MAX      = 4'd2;
    localparam logic [3:0] HR1_MAX_AT_20 = 4'd3;
    localparam logic [3:0] DIGIT_MAX     = 4'd9;

    // Field layout of the 16-bit HHMM word, most significant digit first
    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic [3:0] m10;
        logic [3:0] m1;
    } hhmm_t;

    // Upper limit of the hour-unit digit, which depends on the hour-tens digit
    function automatic logic [3:0] hr1_max(input logic [3:0] h10);
        logic [3:0] lim_s;
        if (h10 == HR10_MAX) begin
            lim_s = HR1_MAX_AT_20;
        end else begin
            lim_s = DIGIT_MAX;
        end
        return lim_s;
    endfunction

    // True when every digit of an HHMM word is a legal 24 h time digit
    function automatic logic hhmm_valid(input hhmm_t t);
        logic ok_s;
        if (t.h10 > HR10_MAX) begin
            ok_s = 1'b0;
        end else if (t.h1 > hr1_max(t.h10)) begin
            ok_s = 1'b0;
        end else if (t.m10 > MIN10_MAX) begin
            ok_s = 1'b0;
        end else if (t.m1 > DIGIT_MAX) begin
            ok_s = 1'b0;
        end else begin
            ok_s = 1'b1;
        end
        return ok_s;
    endfunction

endpackage

// File: rtl/time_counter_bcd_digit.sv
// Single BCD digit counting 0..max with wrap. carry flags that an increment
// wraps this digit and must ripple into the next one. Load beats increment.
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] ld_val,
    input  logic [3:0] max,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_r;

    // ">=" keeps the digit legal even if max drops below the current value
    assign carry = inc && (q_r >= max);
    assign q     = q_r;

    // Digit register: reset, load, or modular increment
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 4'd0;
        end else if (load) begin
            q_r <= ld_val;
        end else if (inc) begin
            if (q_r >= max) begin
                q_r <= 4'd0;
            end else begin
                q_r <= q_r + 4'd1;
            end
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/time_counter.sv
// 24 h BCD time-of-day counter HH:MM:SS driven by a 1 s prescaler.
// Accepts a confirmed HHMM value from the keyboard; invalid values are
// rejected with a one-cycle load_err strobe.
// Optional hourly chime: define TIME_CNT_CHIME_EN to build it in.
import time_counter_pkg::*;

module time_counter #(
    parameter int TICK_CNT  = 50_000_000,
    parameter int CHIME_LEN = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        data_vld,
    output logic [15:0] time_out,
    output logic [7:0]  sec_out,
    output logic        sec_pulse,
    output logic        day_pulse,
    output logic        load_err,
    output logic        chime
);

    localparam int              PW         = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_CNT - 1);

    hhmm_t       ld_s;
    logic        ld_ok_s;
    logic        tick_s;
    logic        step_s;
    logic [PW-1:0] presc_r;
    logic        sec_pulse_r;
    logic        day_pulse_r;
    logic        load_err_r;

    logic [3:0] s1_q_s, s10_q_s, m1_q_s, m10_q_s, h1_q_s, h10_q_s;
    logic       s1_c_s, s10_c_s, m1_c_s, m10_c_s, h1_c_s, h10_c_s;

    assign ld_s    = hhmm_t'(data_in);
    assign ld_ok_s = data_vld && hhmm_valid(ld_s);
    assign tick_s  = en && (presc_r == PRESC_LAST);
    // A valid load on the tick cycle swallows that tick
    assign step_s  = tick_s && !ld_ok_s;

    bcd_digit u_s1  (.clk(clk), .rst(rst), .inc(step_s),  .load(ld_ok_s), .ld_val(4'd0),
                     .max(DIGIT_MAX), .q(s1_q_s), .carry(s1_c_s));
    bcd_digit u_s10 (.clk(clk), .rst(rst), .inc(s1_c_s),  .load(ld_ok_s), .ld_val(4'd0),
                     .max(SEC10_MAX), .q(s10_q_s), .carry(s10_c_s));
    bcd_digit u_m1  (.clk(clk), .rst(rst), .inc(s10_c_s), .load(ld_ok_s), .ld_val(ld_s.m1),
                     .max(DIGIT_MAX), .q(m1_q_s), .carry(m1_c_s));
    bcd_digit u_m10 (.clk(clk), .rst(rst), .inc(m1_c_s),  .load(ld_ok_s), .ld_val(ld_s.m10),
                     .max(MIN10_MAX), .q(m10_q_s), .carry(m10_c_s));
    bcd_digit u_h1  (.clk(clk), .rst(rst), .inc(m10_c_s), .load(ld_ok_s), .ld_val(ld_s.h1),
                     .max(hr1_max(h10_q_s)), .q(h1_q_s), .carry(h1_c_s));
    bcd_digit u_h10 (.clk(clk), .rst(rst), .inc(h1_c_s),  .load(ld_ok_s), .ld_val(ld_s.h10),
                     .max(HR10_MAX), .q(h10_q_s), .carry(h10_c_s));

    // 1 s prescaler: cleared by a valid load, frozen while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (ld_ok_s) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else if (en) begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            presc_r <= presc_r;
        end
    end

    // One-cycle strobes, aligned with the digit update they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_pulse_r <= 1'b0;
            day_pulse_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            sec_pulse_r <= step_s;
            day_pulse_r <= h10_c_s;
            load_err_r  <= data_vld && !ld_ok_s;
        end
    end

    assign time_out  = {h10_q_s, h1_q_s, m10_q_s, m1_q_s};
    assign sec_out   = {s10_q_s, s1_q_s};
    assign sec_pulse = sec_pulse_r;
    assign day_pulse = day_pulse_r;
    assign load_err  = load_err_r;

`ifdef TIME_CNT_CHIME_EN
    localparam int CW = $clog2(CHIME_LEN + 1);

    logic [CW-1:0] chime_cnt_r;
    logic          chime_r;

    // Hourly chime: m10 carry marks the step onto MM:SS = 00:00
    always_ff @(posedge clk) begin
        if (rst) begin
            chime_r     <= 1'b0;
            chime_cnt_r <= '0;
        end else if (ld_ok_s) begin
            chime_r     <= 1'b0;
            chime_cnt_r <= '0;
        end else if (m10_c_s) begin
            chime_r     <= 1'b1;
            chime_cnt_r <= CW'(CHIME_LEN - 1);
        end else if (chime_r) begin
            if (chime_cnt_r == '0) begin
                chime_r <= 1'b0;
            end else begin
                chime_cnt_r <= chime_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            chime_r     <= chime_r;
            chime_cnt_r <= chime_cnt_r;
        end
    end

    assign chime = chime_r;
`else
    // Chime feature absent: output is a constant, CHIME_LEN only documents the interface
    localparam logic CHIME_OFF = (CHIME_LEN >= 0) ? 1'b0 : 1'b0;
    assign chime = CHIME_OFF;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter (TICK_CNT=10, CHIME_LEN=4).
// Reference model keeps time as seconds-of-day and converts to BCD.
module tb_time_counter;

    localparam int TICK = 10;
    localparam int CLEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        data_vld = 1'b0;
    logic [15:0] time_out;
    logic [7:0]  sec_out;
    logic        sec_pulse, day_pulse, load_err, chime;

    int checks = 0;
    int fails  = 0;

    // reference model state
    int m_tod = 0;
    int m_pc = 0;
    int m_crem = 0;
    bit m_sp = 1'b0, m_dp = 1'b0, m_err = 1'b0;

    time_counter #(.TICK_CNT(TICK), .CHIME_LEN(CLEN)) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .data_vld(data_vld),
        .time_out(time_out), .sec_out(sec_out), .sec_pulse(sec_pulse),
        .day_pulse(day_pulse), .load_err(load_err), .chime(chime)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [15:0] data;
        logic [15:0] exp_time;
        logic [7:0]  exp_sec;
        bit          exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd_hhmm(input int tod);
        int h, m;
        h = tod / 3600;
        m = (tod / 60) % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [7:0] bcd_ss(input int tod);
        int s;
        s = tod % 60;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit load_ok(input logic [15:0] d);
        int h10, h1, m10, m1;
        h10 = int'(d[15:12]); h1 = int'(d[11:8]); m10 = int'(d[7:4]); m1 = int'(d[3:0]);
        return (h10 * 10 + h1 <= 23) && (h1 <= 9) && (m10 <= 5) && (m1 <= 9);
    endfunction

    task automatic model_step();
        bit tick, hour;
        hour = 1'b0;
        if (rst) begin
            m_tod = 0; m_pc = 0; m_crem = 0; m_sp = 0; m_dp = 0; m_err = 0;
        end else if (data_vld && load_ok(data_in)) begin
            m_tod = (int'(data_in[15:12]) * 10 + int'(data_in[11:8])) * 3600
                  + (int'(data_in[7:4]) * 10 + int'(data_in[3:0])) * 60;
            m_pc = 0; m_crem = 0; m_sp = 0; m_dp = 0; m_err = 0;
        end else begin
            tick = en && (m_pc == TICK - 1);
            m_err = data_vld;
            m_sp = 0; m_dp = 0;
            if (tick) begin
                m_tod = (m_tod + 1) % 86400;
                m_sp = 1;
                m_dp = (m_tod == 0);
                m_pc = 0;
                hour = (m_tod % 3600 == 0);
            end else if (en) begin
                m_pc++;
            end
            if (hour) m_crem = CLEN;
            else if (m_crem > 0) m_crem--;
        end
    endtask

    task automatic check_model();
        check("time", time_out, bcd_hhmm(m_tod));
        check("sec", 16'(sec_out), 16'(bcd_ss(m_tod)));
        check("sec_pulse", 16'(sec_pulse), 16'(m_sp));
        check("day_pulse", 16'(day_pulse), 16'(m_dp));
        check("load_err", 16'(load_err), 16'(m_err));
`ifdef TIME_CNT_CHIME_EN
        check("chime", 16'(chime), 16'(m_crem > 0));
`else
        check("chime", 16'(chime), 16'h0000);
`endif
    endtask

    task automatic cycle(input bit chk);
        @(posedge clk);
        model_step();
        #1;
        if (chk) check_model();
    endtask

    task automatic load(input logic [15:0] d);
        data_vld = 1'b1; data_in = d;
        cycle(1);
        data_vld = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1);
    endtask

    int cnt, cnt2, lat;
    logic [15:0] held_t;
    logic [7:0]  held_s;
    logic [15:0] corner[5];

    initial begin
        // rst, vld, data, expected time, expected sec, expected load_err (en=0 throughout)
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 16'h1234, 16'h0000, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h1234, 16'h1234, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h2400, 16'h1234, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 16'h1260, 16'h1234, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 16'h2359, 16'h2359, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h1a00, 16'h2359, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 16'h0959, 16'h0959, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h2000, 16'h2000, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'h1999, 16'h2000, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 16'h3000, 16'h2000, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 16'h2000, 8'h00, 1'b0};
        corner = '{16'h2359, 16'h0959, 16'h1959, 16'h2300, 16'h0000};

        en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; data_vld = vecs[i].vld; data_in = vecs[i].data;
            cycle(0);
            check("tbl_time", time_out, vecs[i].exp_time);
            check("tbl_sec", 16'(sec_out), 16'(vecs[i].exp_sec));
            check("tbl_err", 16'(load_err), 16'(vecs[i].exp_err));
            check("tbl_pulse", 16'(sec_pulse), 16'h0000);
        end
        data_vld = 1'b0;

        // reset 3 cycles then 10 enabled cycles give the first second
        rst = 1'b1;
        run(3);
        rst = 1'b0; en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            if (sec_pulse) cnt++;
        end
        check("first_sec", 16'(sec_out), 16'h0001);
        check("first_sec_pulses", 16'(cnt), 16'd1);

        // valid load on the exact tick cycle wins over the tick
        for (int k = 0; k < 2 * TICK && m_pc != TICK - 1; k++) cycle(1);
        load(16'h1223);
        check("ld_tick_time", time_out, 16'h1223);
        check("ld_tick_sec", 16'(sec_out), 16'h0000);
        check("ld_tick_pulse", 16'(sec_pulse), 16'h0000);

        // en low mid-count freezes everything; resumes with remaining count
        run(4);
        held_t = time_out; held_s = sec_out;
        en = 1'b0; cnt = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1);
            if (sec_pulse || day_pulse || load_err) cnt++;
        end
        check("frz_time", time_out, held_t);
        check("frz_sec", 16'(sec_out), 16'(held_s));
        check("frz_strobes", 16'(cnt), 16'd0);
        en = 1'b1; lat = 0;
        for (int i = 1; i <= 3 * TICK && lat == 0; i++) begin
            cycle(1);
            if (sec_pulse) lat = i;
        end
        check("resume_latency", 16'(lat), 16'd6);

        // day rollover
        load(16'h2359);
        run(59 * TICK);
        check("pre_roll_time", time_out, 16'h2359);
        check("pre_roll_sec", 16'(sec_out), 16'h0059);
        cnt = 0;
        for (int i = 0; i < TICK; i++) begin
            cycle(1);
            if (day_pulse) cnt++;
        end
        check("roll_time", time_out, 16'h0000);
        check("roll_sec", 16'(sec_out), 16'h0000);
        check("roll_day_pulses", 16'(cnt), 16'd1);

        // hourly chime at 10:00:00
        load(16'h0959);
        run(59 * TICK);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 2 * TICK; i++) begin
            cycle(1);
            if (chime) cnt++;
            if (sec_pulse && time_out == 16'h1000 && sec_out == 8'h00) cnt2++;
        end
        check("hour_reached", 16'(cnt2), 16'd1);
`ifdef TIME_CNT_CHIME_EN
        check("chime_len", 16'(cnt), 16'(CLEN));
`else
        check("chime_len", 16'(cnt), 16'd0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 7) != 0);
            data_vld = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0: data_in = 16'($urandom_range(0, 65535));
                1: data_in = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                default: data_in = corner[$urandom_range(0, 4)];
            endcase
            cycle(1);
        end
        rst = 1'b0; data_vld = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
